fp_unit_arbiter: RTL and testbench
==================================

Name: fp_unit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multicycle single-precision floating-point unit (e.g. the CORDIC top, start/done style) among NREQ requesters. Captures the winning requester's IEEE-754 operand, issues a one-cycle start pulse to the unit and waits for its done pulse, with a watchdog timeout. Returns the result to the winner with a one-cycle ack. Sits between the input/sum front-end clients and the shared CORDIC datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, operand/result width (IEEE-754 single)
TIMEOUT, 256, max cycles in WAIT before abort (≥2)
TW, 9, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
req  in  NREQ  per-requester request level; held high with stable data until ack
req_data  in  NREQ*DW  packed operands, requester i at bits [i*DW +: DW]
ack  out  NREQ  one-hot, one-cycle pulse: result for requester i valid this cycle
rsp_result  out  DW  result, valid while any ack bit is high
rsp_err  out  1  high with ack when the op timed out
busy  out  1  high when state ≠ IDLE
unit_start  out  1  one-cycle start pulse to the shared unit
unit_data  out  DW  operand to the unit; stable from ISSUE until next ISSUE
unit_done  in  1  one-cycle pulse from the unit: unit_result valid
unit_result  in  DW  unit output

Behaviour:
- Reset (reset_n=0 at rising edge): state=IDLE; ack=0, rsp_result=0, rsp_err=0, unit_start=0, unit_data=0, busy=0; timeout counter=0; last-grant pointer=NREQ-1 (so requester 0 has top priority first). Reset mid-operation aborts silently: no ack issued; the unit is reset by the same reset_n.
- All outputs registered. States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if req≠0, pick winner g = first set bit scanning from (last+1) mod NREQ upward with wrap; latch g, latch req_data[g] into unit_data, last←g, go ISSUE. req==0 → stay.
- ISSUE (1 cycle): unit_start=1; counter←0; go WAIT.
- WAIT: unit_start=0. unit_done=1 → capture unit_result into rsp_result, rsp_err←0, go RESPOND. Else counter+1; counter reaching TIMEOUT-1 without done → rsp_result←32'h7FC00000 (qNaN), rsp_err←1, go RESPOND. done and timeout in the same cycle: done wins.
- RESPOND (1 cycle): ack[g]=1, rsp_result/rsp_err valid; go IDLE. ack, rsp_err cleared next cycle; rsp_result holds.
- Requester rule: drop req at the edge where its ack is high; a req still high in IDLE is a new request.
- Changes to req/req_data of non-granted requesters never disturb an op in flight; operand is captured only in IDLE.
- unit_done outside WAIT is ignored (including late done after timeout).
- Latency: req high at edge E0 → unit_start high cycle E0+1 → earliest done sampled at E0+2 → ack high cycle E0+3. Unit latency L (done L cycles after start) → ack at E0+2+L.
- Throughput: one op per L+3 cycles; with all req held, grants rotate 0,1,2,3,0…
- No back-to-back without IDLE: min one IDLE cycle between ops.

Decomposition:
- Shared package fp_ctrl_pkg: state enum (IDLE/ISSUE/WAIT/RESPOND), FP_QNAN=32'h7FC00000, FP_W=32.
- Sub-module rr_priority_picker (combinational: req vector + last pointer → one-hot grant, index, valid); reused by future multi-port FP schedulers.

Test Plan:
- Single req: reset, req[0]=1 with 32'h437F0000 (255.0), unit model L=5 returns 32'h3F800000 → unit_start one cycle at E0+1 with unit_data=32'h437F0000; ack=4'b0001 at E0+7, rsp_result=32'h3F800000, rsp_err=0.
- Round robin: req=4'b1111 held (re-raised after ack), distinct operands 1.0/2.0/3.0/4.0 → grant order 0,1,2,3,0; each ack one-hot matching its own echoed operand.
- Skip/wrap: after grant to 2, req=4'b0011 → next grant 0, then 1; no ack to idle requesters.
- Timeout: unit model never asserts done → ack at E0+1+TIMEOUT+1 with rsp_result=32'h7FC00000, rsp_err=1; a late unit_done in IDLE ignored (no ack).
- Done on timeout boundary: done in the final WAIT cycle → real result, rsp_err=0.
- Reset mid-WAIT: reset_n=0 one cycle → next cycle all outputs 0, busy=0, no ack; req[0] then served first.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the floating-point unit control blocks:
// sequencer states and IEEE-754 single-precision constants.
package fp_ctrl_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } fp_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from the slot after the last grant, wrapping at NREQ.
module rr_priority_picker #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [LW-1:0]   idx,
    output logic            valid
);

    logic [LW-1:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = LW'((int'(last) + 1 + i) % NREQ);
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one start/done floating-point unit among NREQ requesters with
// round-robin selection, a WAIT watchdog and a one-cycle ack per result.
module fp_unit_arbiter
    import fp_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256,
    parameter int TW      = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     ack,
    output logic [DW-1:0]       rsp_result,
    output logic                rsp_err,
    output logic                busy,
    output logic                unit_start,
    output logic [DW-1:0]       unit_data,
    input  logic                unit_done,
    input  logic [DW-1:0]       unit_result
);

    localparam int LW = $clog2(NREQ);

    logic [NREQ-1:0][DW-1:0] ops;
    assign ops = req_data;

    fp_state_e       state;
    logic [LW-1:0]   last;
    logic [NREQ-1:0] gnt_q;
    logic [TW-1:0]   cnt;

    logic [NREQ-1:0] pick_gnt;
    logic [LW-1:0]   pick_idx;
    logic            pick_vld;

    rr_priority_picker #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_pick (
        .req   (req),
        .last  (last),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= LW'(NREQ - 1);
            gnt_q      <= '0;
            cnt        <= '0;
            ack        <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            unit_start <= 1'b0;
            unit_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Operand is sampled only here, so later req_data churn is harmless.
                    if (pick_vld) begin
                        gnt_q      <= pick_gnt;
                        last       <= pick_idx;
                        unit_data  <= ops[pick_idx];
                        unit_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    unit_start <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last watchdog cycle still delivers a real result.
                    if (unit_done) begin
                        rsp_result <= unit_result;
                        rsp_err    <= 1'b0;
                        ack        <= gnt_q;
                        state      <= RESPOND;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        rsp_result <= DW'(FP_QNAN);
                        rsp_err    <= 1'b1;
                        ack        <= gnt_q;
                        state      <= RESPOND;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                RESPOND: begin
                    ack     <= '0;
                    rsp_err <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: table-driven round-robin vectors plus directed
// latency, watchdog, boundary and reset-abort sequences against a unit model.
module tb_fp_unit_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 20;
    localparam int TW      = 5;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     ack;
    logic [DW-1:0]       rsp_result;
    logic                rsp_err;
    logic                busy;
    logic                unit_start;
    logic [DW-1:0]       unit_data;
    logic                unit_done;
    logic [DW-1:0]       unit_result;

    logic mdl_done = 1'b0;
    logic inj_done;
    assign unit_done = mdl_done | inj_done;

    fp_unit_arbiter #(
        .NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
        .unit_start(unit_start), .unit_data(unit_data),
        .unit_done(unit_done), .unit_result(unit_result)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        int         lat;
        int         g;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        tbl[12];
    logic [31:0] opv[NREQ];
    int          lat;
    logic        fixed_en;
    logic [31:0] fixed_val;
    logic [31:0] exp_op;
    int          cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = opv[i];
    endtask

    task automatic issue(input logic [3:0] r, input int g, input int l,
                         input logic [31:0] res, input logic err);
        exp_t e;
        e.ack = 4'b0001 << g;
        e.res = res;
        e.err = err;
        sbq.push_back(e);
        lat    = l;
        exp_op = opv[g];
        req    = r;
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < budget);
        if (ack == '0) begin
            tests++;
            failed++;
            $display("FAIL ack_wait: no ack within %0d cycles at %0t", budget, $time);
        end
    endtask

    // Unit model: done L cycles after the start pulse; L=0 means never.
    int          rem = 0;
    logic [31:0] cap = '0;
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!reset_n) begin
            rem <= 0;
        end else if (unit_start && lat > 0) begin
            cap <= unit_data;
            if (lat == 1) begin
                mdl_done    <= 1'b1;
                unit_result <= fixed_en ? fixed_val : unit_data;
            end else begin
                rem <= lat - 1;
            end
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                mdl_done    <= 1'b1;
                unit_result <= fixed_en ? fixed_val : cap;
            end
        end
    end

    always @(negedge clk) begin
        if (unit_start) chk("unit_data_at_start", unit_data, exp_op);
        if (ack != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {28'b0, ack}, 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack", {28'b0, ack}, {28'b0, mon_e.ack});
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b1111, 2, 0};
        tbl[1]  = '{4'b1111, 1, 1};
        tbl[2]  = '{4'b1111, 3, 2};
        tbl[3]  = '{4'b1111, 4, 3};
        tbl[4]  = '{4'b1111, 1, 0};
        tbl[5]  = '{4'b1111, 2, 1};
        tbl[6]  = '{4'b1111, 1, 2};
        tbl[7]  = '{4'b0011, 1, 0};
        tbl[8]  = '{4'b0011, 3, 1};
        tbl[9]  = '{4'b1000, 1, 3};
        tbl[10] = '{4'b0101, 2, 0};
        tbl[11] = '{4'b0101, 1, 2};

        opv[0] = 32'h3F80_0000;
        opv[1] = 32'h4000_0000;
        opv[2] = 32'h4040_0000;
        opv[3] = 32'h4080_0000;
        reset_n = 1'b0; req = '0; inj_done = 1'b0; lat = 0;
        fixed_en = 1'b0; fixed_val = '0; exp_op = '0; unit_result = '0;
        load_data();

        repeat (3) @(negedge clk);
        chk("rst_ack", {28'b0, ack}, 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_unit_start", {31'b0, unit_start}, 32'h0);
        chk("rst_unit_data", unit_data, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request, unit latency 5: ack lands 7 cycles after the request edge.
        opv[0] = 32'h437F_0000;
        load_data();
        fixed_en  = 1'b1;
        fixed_val = 32'h3F80_0000;
        issue(4'b0001, 0, 5, 32'h3F80_0000, 1'b0);
        @(negedge clk);
        chk("single_start", {31'b0, unit_start}, 32'h1);
        chk("single_busy", {31'b0, busy}, 32'h1);
        wait_ack(50, cyc);
        chk("single_latency", cyc + 1, 7);
        req = '0;
        @(negedge clk);
        chk("post_ack_clear", {28'b0, ack}, 32'h0);
        chk("post_err_clear", {31'b0, rsp_err}, 32'h0);
        chk("post_result_hold", rsp_result, 32'h3F80_0000);
        chk("post_busy", {31'b0, busy}, 32'h0);
        fixed_en = 1'b0;
        opv[0] = 32'h3F80_0000;
        load_data();

        // Fresh pointer so rotation starts at requester 0.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].req, tbl[i].g, tbl[i].lat, opv[tbl[i].g], 1'b0);
            wait_ack(50, cyc);
        end
        req = '0;
        @(negedge clk);

        // Watchdog abort, then a stray done that must not produce an ack.
        issue(4'b0001, 0, 0, 32'h7FC0_0000, 1'b1);
        wait_ack(TIMEOUT + 20, cyc);
        chk("timeout_latency", cyc, TIMEOUT + 2);
        req = '0;
        inj_done = 1'b1;
        repeat (2) @(negedge clk);
        inj_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_done_busy", {31'b0, busy}, 32'h0);
        chk("late_done_err", {31'b0, rsp_err}, 32'h0);
        chk("late_done_hold", rsp_result, 32'h7FC0_0000);

        // Done on the final WAIT cycle wins over the watchdog.
        issue(4'b0010, 1, TIMEOUT, opv[1], 1'b0);
        wait_ack(TIMEOUT + 20, cyc);
        chk("boundary_latency", cyc, TIMEOUT + 2);
        req = '0;
        @(negedge clk);

        // Reset while waiting aborts silently and restores requester-0 priority.
        lat = 0; exp_op = opv[2]; req = 4'b0100;
        repeat (5) @(negedge clk);
        chk("wait_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_ack", {28'b0, ack}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_unit_start", {31'b0, unit_start}, 32'h0);
        chk("abort_unit_data", unit_data, 32'h0);
        chk("abort_rsp_result", rsp_result, 32'h0);
        chk("abort_rsp_err", {31'b0, rsp_err}, 32'h0);
        reset_n = 1'b1;
        issue(4'b0101, 0, 1, opv[0], 1'b0);
        wait_ack(50, cyc);
        req = '0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
